// File: rtl/regfile_dump.sv
// Register-file dump sequencer: sweeps an inclusive, wrapping address range two
// registers per fetch and streams each word with its address over valid/ready.
module regfile_dump #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] raddr1,
  output logic [ADDR_W-1:0] raddr2,
  input  logic [DATA_W-1:0] rdata1,
  input  logic [DATA_W-1:0] rdata2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SEND0,
    S_SEND1,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic [DATA_W-1:0] buf0_q, buf0_d;
  logic [DATA_W-1:0] buf1_q, buf1_d;

  logic [ADDR_W-1:0] ptr_inc;
  logic [ADDR_W-1:0] span;
  logic [ADDR_W:0]   count;
  logic              last_word;

  // Subtraction wraps naturally in ADDR_W bits, so first > last sweeps through 0.
  assign span      = last_addr - first_addr;
  assign count     = (ADDR_W+1)'(span) + (ADDR_W+1)'(1);
  assign ptr_inc   = ptr_q + ADDR_W'(1);
  assign last_word = (remaining_q == (ADDR_W+1)'(1));

  assign raddr1 = ptr_q;
  assign raddr2 = ptr_inc;
  assign busy   = (state_q != S_IDLE);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    buf0_d      = buf0_q;
    buf1_d      = buf1_q;
    out_valid   = 1'b0;
    out_data    = '0;
    out_addr    = '0;
    out_last    = 1'b0;
    done        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ptr_d       = first_addr;
          remaining_d = count;
          state_d     = S_FETCH;
        end
      end
      S_FETCH: begin
        buf0_d  = rdata1;
        buf1_d  = rdata2;
        state_d = S_SEND0;
      end
      S_SEND0: begin
        out_valid = 1'b1;
        out_data  = buf0_q;
        out_addr  = ptr_q;
        out_last  = last_word;
        if (out_ready) begin
          remaining_d = remaining_q - (ADDR_W+1)'(1);
          state_d     = last_word ? S_DONE : S_SEND1;
        end
      end
      S_SEND1: begin
        out_valid = 1'b1;
        out_data  = buf1_q;
        out_addr  = ptr_inc;
        out_last  = last_word;
        if (out_ready) begin
          remaining_d = remaining_q - (ADDR_W+1)'(1);
          if (last_word) begin
            state_d = S_DONE;
          end else begin
            ptr_d   = ptr_q + ADDR_W'(2);
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      remaining_q <= '0;
      // NOTE: the word buffers are plain flops, so they are reset to give a defined dump state.
      buf0_q      <= '0;
      buf1_q      <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
    end
  end

endmodule
